io_fifo_ctrl: RTL and testbench

//  Buffers and sequences UART traffic for the pipelined core. Received bytes queue in an RX FIFO
//  and are handed to the decode-stage In instruction; Out bytes from the execute stage queue in a
//  TX FIFO and are issued one at a time to the UART transmitter. Generates in_stall/out_stall
//  for hazard_unit, so the core never loses a byte or overruns the transmitter.

---
 rtl/io_pkg.sv | 14 +
 rtl/io_fifo_ctrl_if.sv | 37 +++
 rtl/sync_fifo.sv | 54 +++++
 rtl/io_fifo_ctrl.sv | 128 ++++++++++++
 tb/tb_io_fifo_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// Shared defaults and TX sequencer state encoding for the UART I/O FIFO controller.
package io_pkg;

  localparam int DEPTH_LOG2_DEF  = 4;
  localparam int DATA_W_DEF      = 8;
  localparam int TX_WAIT_MAX_DEF = 4;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_WAIT_BUSY = 2'd1,
    TX_WAIT_DONE = 2'd2
  } txState_t;

endpackage

// File: rtl/io_fifo_ctrl_if.sv
// Core/UART-facing signal bundle of the I/O FIFO controller.
// slave = the controller itself, master = the core/UART side driving it.
interface io_fifo_ctrl_if #(
  parameter int DEPTH_LOG2 = io_pkg::DEPTH_LOG2_DEF,
  parameter int DATA_W     = io_pkg::DATA_W_DEF
);
  // uart_rx side
  logic [DATA_W-1:0]   rx_data;
  logic                rx_valid;
  logic                rx_ferr;
  // decode-stage In instruction
  logic                in_req;
  logic                in_take;
  logic [DATA_W-1:0]   in_data;
  logic                in_stall;
  // execute-stage Out instruction
  logic                out_req;
  logic [DATA_W-1:0]   out_data;
  logic                out_stall;
  // uart_tx side
  logic [DATA_W-1:0]   tx_data;
  logic                tx_start;
  logic                tx_busy;
  // status
  logic                rx_overflow;
  logic [DEPTH_LOG2:0] rx_count;

  modport slave (
    input  rx_data, rx_valid, rx_ferr, in_req, in_take, out_req, out_data, tx_busy,
    output in_data, in_stall, out_stall, tx_data, tx_start, rx_overflow, rx_count
  );

  modport master (
    output rx_data, rx_valid, rx_ferr, in_req, in_take, out_req, out_data, tx_busy,
    input  in_data, in_stall, out_stall, tx_data, tx_start, rx_overflow, rx_count
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; a pop on empty is ignored.
// popData reads as zero while empty so stale storage never leaks out.
module sync_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                push,
  input  logic [DATA_W-1:0]   pushData,
  input  logic                pop,
  output logic [DATA_W-1:0]   popData,
  output logic [DEPTH_LOG2:0] count
);
  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr;
  logic [DEPTH_LOG2-1:0] rdPtr;
  logic                  empty;
  logic                  full;
  logic                  wrEn;
  logic                  rdEn;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign rdEn    = pop & ~empty;
  assign wrEn    = push & (~full | rdEn);
  assign popData = empty ? '0 : mem[rdPtr];

  // Storage write.
  // NOTE: the data array is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr] <= pushData;
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + 1'b1;
      if (rdEn) rdPtr <= rdPtr + 1'b1;
      if (wrEn && !rdEn)      count <= count + 1'b1;
      else if (rdEn && !wrEn) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/io_fifo_ctrl.sv
// UART I/O FIFO controller: RX FIFO feeding the In instruction, TX FIFO fed by
// Out and drained one byte at a time into the UART transmitter, plus the
// in/out stall signals for the hazard unit and a sticky RX overflow flag.
module io_fifo_ctrl
  import io_pkg::*;
#(
  parameter int DEPTH_LOG2  = DEPTH_LOG2_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TX_WAIT_MAX = TX_WAIT_MAX_DEF
) (
  input  logic           clk,
  input  logic           rstn,
  io_fifo_ctrl_if.slave  bus
);
  localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);
  localparam int                  WAIT_W    = (TX_WAIT_MAX > 1) ? $clog2(TX_WAIT_MAX) : 1;
  localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(TX_WAIT_MAX - 1);

  // ---------------- RX path ----------------
  logic [DEPTH_LOG2:0] rxCount;
  logic                rxPush;
  logic                rxPop;
  logic                rxEmpty;
  logic                rxFull;
  logic                rxOverflow;

  // Framing-error bytes are discarded before they reach the FIFO.
  assign rxPush  = bus.rx_valid & ~bus.rx_ferr;
  assign rxPop   = bus.in_take & bus.in_req;
  assign rxEmpty = (rxCount == '0);
  assign rxFull  = (rxCount == FULL_CNT);

  sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(DATA_W)) u_rxFifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (rxPush),
    .pushData (bus.rx_data),
    .pop      (rxPop),
    .popData  (bus.in_data),
    .count    (rxCount)
  );

  // Sticky overflow: a good byte arrived with nowhere to go.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                         rxOverflow <= 1'b0;
    else if (rxPush && rxFull && !rxPop) rxOverflow <= 1'b1;
  end

  assign bus.rx_count    = rxCount;
  assign bus.rx_overflow = rxOverflow;
  assign bus.in_stall    = bus.in_req & rxEmpty;

  // ---------------- TX path ----------------
  logic [DEPTH_LOG2:0] txCount;
  logic [DATA_W-1:0]   txHead;
  logic                txPush;
  logic                txPop;
  logic                txEmpty;
  logic                txFull;
  txState_t            state;
  txState_t            nextState;
  logic [WAIT_W-1:0]   waitCnt;
  logic [DATA_W-1:0]   txData;
  logic                txStart;

  // Full is taken from the registered count, so a same-cycle pop cannot release the stall.
  assign txEmpty       = (txCount == '0);
  assign txFull        = (txCount == FULL_CNT);
  assign txPush        = bus.out_req & ~txFull;
  assign bus.out_stall = bus.out_req & txFull;

  sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(DATA_W)) u_txFifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (txPush),
    .pushData (bus.out_data),
    .pop      (txPop),
    .popData  (txHead),
    .count    (txCount)
  );

  // TX sequencer state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= TX_IDLE;
    else       state <= nextState;
  end

  // TX sequencer next state and head pop.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    nextState = state;
    txPop     = 1'b0;
    case (state)
      TX_IDLE: begin
        if (!txEmpty && !bus.tx_busy) begin
          txPop     = 1'b1;
          nextState = TX_WAIT_BUSY;
        end
      end
      TX_WAIT_BUSY: begin
        if (bus.tx_busy)              nextState = TX_WAIT_DONE;
        else if (waitCnt == WAIT_LAST) nextState = TX_IDLE;
      end
      TX_WAIT_DONE: begin
        if (!bus.tx_busy) nextState = TX_IDLE;
      end
      default: nextState = TX_IDLE;
    endcase
  end

  // Registered byte/start to the transmitter and the busy-wait timeout counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      txData  <= '0;
      txStart <= 1'b0;
      waitCnt <= '0;
    end else begin
      txStart <= txPop;
      if (txPop) txData <= txHead;
      if (state == TX_WAIT_BUSY && nextState == TX_WAIT_BUSY) waitCnt <= waitCnt + 1'b1;
      else                                                    waitCnt <= '0;
    end
  end

  assign bus.tx_data  = txData;
  assign bus.tx_start = txStart;

endmodule

// File: tb/tb_io_fifo_ctrl.sv
// Self-checking bench for io_fifo_ctrl: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// queue-based behavioural model of the controller.
module tb_io_fifo_ctrl;
  localparam int DL    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int TXW   = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  io_fifo_ctrl_if #(.DEPTH_LOG2(DL), .DATA_W(DW)) bus ();

  io_fifo_ctrl #(.DEPTH_LOG2(DL), .DATA_W(DW), .TX_WAIT_MAX(TXW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mRx[$];
  logic [7:0] mTx[$];
  bit         mOvf      = 1'b0;
  logic [7:0] mTxData   = 8'h00;
  bit         mTxStart  = 1'b0;
  int         mWaitLeft = 0;    // >0: byte handed over, still waiting this many cycles for busy
  bit         mSending  = 1'b0; // transmitter accepted the byte, waiting for it to finish

  task automatic modelReset();
    mRx.delete();
    mTx.delete();
    mOvf      = 1'b0;
    mTxData   = 8'h00;
    mTxStart  = 1'b0;
    mWaitLeft = 0;
    mSending  = 1'b0;
  endtask

  task automatic modelStep();
    bit pop, good, full, txPush;
    pop    = bus.in_take && bus.in_req && (mRx.size() > 0);
    good   = bus.rx_valid && !bus.rx_ferr;
    full   = (mRx.size() == DEPTH);
    txPush = bus.out_req && (mTx.size() < DEPTH);
    if (good && full && !pop) mOvf = 1'b1;
    if (pop) void'(mRx.pop_front());
    if (good && (!full || pop)) mRx.push_back(bus.rx_data);

    mTxStart = 1'b0;
    if (mWaitLeft == 0 && !mSending) begin
      if (mTx.size() > 0 && !bus.tx_busy) begin
        mTxData   = mTx.pop_front();
        mTxStart  = 1'b1;
        mWaitLeft = TXW;
      end
    end else if (mWaitLeft > 0) begin
      if (bus.tx_busy) begin
        mWaitLeft = 0;
        mSending  = 1'b1;
      end else begin
        mWaitLeft--;
      end
    end else if (!bus.tx_busy) begin
      mSending = 1'b0;
    end
    if (txPush) mTx.push_back(bus.out_data);
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) modelReset();
    else       modelStep();
  end

  // ---------------- per-cycle compare ----------------
  bit chkEn = 1'b0;

  always @(negedge clk) begin
    if (chkEn) begin
      check("in_data",     {24'h0, bus.in_data},   (mRx.size() > 0) ? {24'h0, mRx[0]} : 32'h0);
      check("in_stall",    {31'h0, bus.in_stall},  {31'h0, bus.in_req && mRx.size() == 0});
      check("rx_count",    {27'h0, bus.rx_count},  mRx.size());
      check("rx_overflow", {31'h0, bus.rx_overflow}, {31'h0, mOvf});
      check("out_stall",   {31'h0, bus.out_stall}, {31'h0, bus.out_req && mTx.size() == DEPTH});
      check("tx_data",     {24'h0, bus.tx_data},   {24'h0, mTxData});
      check("tx_start",    {31'h0, bus.tx_start},  {31'h0, mTxStart});
    end
  end

  // ---------------- transmitter model and TX monitor ----------------
  int         cyc       = 0;
  int         busyStart = 0;
  int         busyEnd   = 0;
  bit         busyStuck = 1'b0;
  int         busyDelay = 0;
  int         busyLen   = 10;
  bit         sawStart;
  logic [7:0] sent[$];
  int         sentCyc[$];

  always @(posedge clk) begin
    sawStart = bus.tx_start;
    if (sawStart) begin
      sent.push_back(bus.tx_data);
      sentCyc.push_back(cyc);
    end
    cyc++;
    #2;
    if (sawStart) begin
      busyStart = cyc + busyDelay;
      busyEnd   = busyStart + busyLen;
    end
    bus.tx_busy = busyStuck || (cyc >= busyStart && cyc < busyEnd);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idleInputs();
    bus.rx_valid = 1'b0;
    bus.rx_ferr  = 1'b0;
    bus.rx_data  = '0;
    bus.in_req   = 1'b0;
    bus.in_take  = 1'b0;
    bus.out_req  = 1'b0;
    bus.out_data = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    bit released;
    int busyCycles;

    idleInputs();
    bus.in_req = 1'b1;
    repeat (2) @(posedge clk);
    chkEn = 1'b1;

    // Reset values (in_stall follows in_req while empty)
    @(negedge clk);
    check("rst in_stall", {31'h0, bus.in_stall}, 32'h1);
    check("rst rx_count", {27'h0, bus.rx_count}, 32'h0);
    check("rst tx_start", {31'h0, bus.tx_start}, 32'h0);
    check("rst in_data",  {24'h0, bus.in_data},  32'h0);
    tick();
    bus.in_req = 1'b0;
    rstn = 1'b1;

    // 1: two bytes, then In takes them in order
    bus.rx_valid = 1'b1; bus.rx_data = 8'h41; tick();
    bus.rx_data = 8'h42; tick();
    bus.rx_valid = 1'b0; bus.in_req = 1'b1; bus.in_take = 1'b1;
    @(negedge clk);
    check("t1 in_data0", {24'h0, bus.in_data}, 32'h41);
    check("t1 stall0",   {31'h0, bus.in_stall}, 32'h0);
    check("t1 count",    {27'h0, bus.rx_count}, 32'h2);
    tick();
    @(negedge clk);
    check("t1 in_data1", {24'h0, bus.in_data}, 32'h42);
    check("t1 stall1",   {31'h0, bus.in_stall}, 32'h0);
    tick();
    @(negedge clk);
    check("t1 stall_after", {31'h0, bus.in_stall}, 32'h1);
    bus.in_req = 1'b0; bus.in_take = 1'b0;
    tick();

    // 2: byte arriving into an empty FIFO clears the stall one cycle later
    bus.in_req = 1'b1; bus.rx_valid = 1'b1; bus.rx_data = 8'h55;
    @(negedge clk);
    check("t2 stall_t", {31'h0, bus.in_stall}, 32'h1);
    tick();
    bus.rx_valid = 1'b0;
    @(negedge clk);
    check("t2 stall_t1", {31'h0, bus.in_stall}, 32'h0);
    check("t2 in_data",  {24'h0, bus.in_data},  32'h55);
    bus.in_take = 1'b1; tick();
    bus.in_take = 1'b0; bus.in_req = 1'b0;
    @(negedge clk);
    check("t2 drained", {27'h0, bus.rx_count}, 32'h0);
    tick();

    // 3: framing error dropped, then overflow on the 17th byte
    bus.rx_valid = 1'b1; bus.rx_ferr = 1'b1; bus.rx_data = 8'hEE; tick();
    bus.rx_valid = 1'b0; bus.rx_ferr = 1'b0;
    @(negedge clk);
    check("t3 ferr count", {27'h0, bus.rx_count}, 32'h0);
    tick();
    for (int i = 0; i < 17; i++) begin
      bus.rx_valid = 1'b1; bus.rx_data = 8'(8'h60 + i); tick();
    end
    bus.rx_valid = 1'b0;
    @(negedge clk);
    check("t3 full count", {27'h0, bus.rx_count}, 32'd16);
    check("t3 overflow",   {31'h0, bus.rx_overflow}, 32'h1);
    tick();
    bus.in_req = 1'b1; bus.in_take = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("t3 drain order", {24'h0, bus.in_data}, 32'h60 + i);
      tick();
    end
    @(negedge clk);
    check("t3 empty after", {31'h0, bus.in_stall}, 32'h1);
    check("t3 ovf sticky",  {31'h0, bus.rx_overflow}, 32'h1);
    idleInputs();
    tick();

    // 4: two Outs, transmitter busy 1 cycle after start for 10 cycles
    busyDelay = 0; busyLen = 10;
    base = sent.size();
    bus.out_req = 1'b1; bus.out_data = 8'h10; tick();
    bus.out_data = 8'h20; tick();
    bus.out_req = 1'b0;
    for (int i = 0; i < 100 && sent.size() < base + 2; i++) tick();
    check("t4 starts", sent.size(), base + 2);
    if (sent.size() >= base + 2) begin
      check("t4 byte0", {24'h0, sent[base]},     32'h10);
      check("t4 byte1", {24'h0, sent[base + 1]}, 32'h20);
      check("t4 gap after busy", {31'h0, (sentCyc[base + 1] - sentCyc[base]) >= 11}, 32'h1);
    end

    // 5: fill TX with the transmitter stuck busy; 17th Out stalls until a pop
    busyStuck = 1'b1;
    base = sent.size();
    for (int i = 0; i < 16; i++) begin
      bus.out_req = 1'b1; bus.out_data = 8'(i);
      @(negedge clk);
      check("t5 no stall", {31'h0, bus.out_stall}, 32'h0);
      tick();
    end
    bus.out_data = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5 stall held", {31'h0, bus.out_stall}, 32'h1);
      tick();
    end
    busyStuck = 1'b0; busyLen = 2;
    released = 1'b0;
    for (int i = 0; i < 40 && !released; i++) begin
      @(negedge clk);
      if (!bus.out_stall) released = 1'b1;
      else tick();
    end
    check("t5 stall released", {31'h0, released}, 32'h1);
    tick();
    bus.out_req = 1'b0;
    for (int i = 0; i < 600 && sent.size() < base + 17; i++) tick();
    check("t5 sent count", sent.size(), base + 17);
    if (sent.size() >= base + 17) begin
      for (int i = 0; i < 16; i++) check("t5 order", {24'h0, sent[base + i]}, i);
      check("t5 last", {24'h0, sent[base + 16]}, 32'hAA);
    end

    // 6: reset while the transmitter is busy with bytes still queued
    busyDelay = 0; busyLen = 10;
    for (int i = 0; i < 4; i++) begin
      bus.out_req = 1'b1; bus.out_data = 8'(8'hB0 + i);
      bus.rx_valid = (i < 3); bus.rx_data = 8'(8'hC0 + i);
      tick();
    end
    idleInputs();
    busyCycles = 0;
    for (int i = 0; i < 50 && busyCycles < 2; i++) begin
      @(negedge clk);
      if (bus.tx_busy) busyCycles++;
      tick();
    end
    check("t6 reached busy", {31'h0, busyCycles >= 2}, 32'h1);
    @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    check("t6 rx_count",  {27'h0, bus.rx_count},  32'h0);
    check("t6 tx_start",  {31'h0, bus.tx_start},  32'h0);
    check("t6 tx_data",   {24'h0, bus.tx_data},   32'h0);
    check("t6 overflow",  {31'h0, bus.rx_overflow}, 32'h0);
    check("t6 in_data",   {24'h0, bus.in_data},   32'h0);
    @(posedge clk); #2;
    rstn = 1'b1;
    base = sent.size();
    repeat (40) tick();
    check("t6 no stale tx", sent.size(), base);

    // Randomized traffic: first phase favours filling, second favours draining
    for (int n = 0; n < 3000; n++) begin
      bus.rx_valid = ($urandom % 100) < 40;
      bus.rx_ferr  = ($urandom % 100) < 10;
      bus.rx_data  = 8'($urandom);
      bus.in_req   = ($urandom % 100) < 60;
      bus.in_take  = ($urandom % 100) < ((n < 1500) ? 20 : 75);
      bus.out_req  = ($urandom % 100) < 45;
      bus.out_data = 8'($urandom);
      busyDelay    = $urandom_range(0, 5);
      busyLen      = (n < 1500) ? $urandom_range(0, 12) : $urandom_range(0, 4);
      tick();
    end
    idleInputs();
    repeat (20) tick();

    chkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
